// File: rtl/rggen_bit_field_event_counter_pkg.sv
// Shared action codes, counter mode constants and the per-channel access decode
// for the event-counter bit field.
package rggen_bit_field_event_counter_pkg;

  typedef enum logic [1:0] {
    RggenReadDefault = 2'd0,
    RggenReadClear   = 2'd1,
    RggenReadNone    = 2'd2
  } rggen_read_action_e;

  typedef enum logic [1:0] {
    RggenWriteDefault = 2'd0,
    RggenWrite1Clear  = 2'd1,
    RggenWriteNone    = 2'd2
  } rggen_write_action_e;

  typedef enum logic {
    RggenHwAccess = 1'b0,
    RggenSwAccess = 1'b1
  } rggen_precedence_e;

  localparam bit RggenCounterWrap     = 1'b1;
  localparam bit RggenCounterSaturate = 1'b0;

  typedef struct packed {
    logic read;
    logic write;
  } counter_access_t;

  // A channel access only counts when the field actually implements that direction.
  function automatic counter_access_t decode_access(
    input logic                valid,
    input logic                write_enable,
    input logic                read_hit,
    input logic                write_hit,
    input rggen_read_action_e  read_action,
    input rggen_write_action_e write_action
  );
    counter_access_t access;
    access.read  = valid && read_hit && (read_action != RggenReadNone);
    access.write = valid && write_enable && write_hit && (write_action != RggenWriteNone);
    return access;
  endfunction

endpackage

// File: rtl/rggen_event_counter_channel.sv
// One event counter: count register, sticky overflow flag, threshold compare and
// optional registered SW access trigger pulses.
module rggen_event_counter_channel
  import rggen_bit_field_event_counter_pkg::*;
#(
  parameter int unsigned         WIDTH             = 8,
  parameter logic [WIDTH-1:0]    INITIAL_VALUE     = '0,
  parameter rggen_read_action_e  SW_READ_ACTION    = RggenReadDefault,
  parameter rggen_write_action_e SW_WRITE_ACTION   = RggenWriteDefault,
  parameter rggen_precedence_e   PRECEDENCE_ACCESS = RggenHwAccess,
  parameter bit                  WRAP              = RggenCounterSaturate,
  parameter logic [WIDTH-1:0]    THRESHOLD         = '1,
  parameter bit                  TRIGGER           = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  counter_access_t  i_access,
  input  logic [WIDTH-1:0] i_write_mask,
  input  logic [WIDTH-1:0] i_write_data,
  input  logic             i_hw_up,
  input  logic             i_hw_down,
  input  logic             i_hw_clear,
  output logic [WIDTH-1:0] o_value,
  output logic             o_overflow,
  output logic             o_threshold,
  output logic             o_write_trigger,
  output logic             o_read_trigger
);

  localparam logic [WIDTH-1:0] AllOnes = '1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] written;
  logic [WIDTH-1:0] base;
  logic             apply_delta, keep_overflow;
  logic             inc, dec, at_max, at_min, ovf_event;

  always_comb begin
    if (SW_WRITE_ACTION == RggenWrite1Clear) begin
      written = count_q & ~(i_write_data & i_write_mask);
    end else begin
      written = (count_q & ~i_write_mask) | (i_write_data & i_write_mask);
    end

    base          = count_q;
    apply_delta   = 1'b1;
    keep_overflow = 1'b1;
    if (i_access.write) begin
      base          = written;
      apply_delta   = (PRECEDENCE_ACCESS == RggenHwAccess);
      keep_overflow = 1'b0;
    end else if (i_access.read && (SW_READ_ACTION == RggenReadClear)) begin
      // Clear-on-read still absorbs this cycle's event so nothing is lost.
      base          = '0;
      keep_overflow = 1'b0;
    end

    inc       = apply_delta && i_hw_up && !i_hw_down;
    dec       = apply_delta && i_hw_down && !i_hw_up;
    at_max    = (base == AllOnes);
    at_min    = (base == '0);
    ovf_event = (inc && at_max) || (dec && at_min);

    count_d = base;
    if (inc && (!at_max || WRAP)) begin
      count_d = base + 1'b1;
    end else if (dec && (!at_min || WRAP)) begin
      count_d = base - 1'b1;
    end
    overflow_d = (keep_overflow && overflow_q) || ovf_event;

    if (i_hw_clear) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q    <= INITIAL_VALUE;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_value     = count_q;
  assign o_overflow  = overflow_q;
  assign o_threshold = (count_q >= THRESHOLD);

  if (TRIGGER) begin : g_trigger
    logic write_trigger_q, read_trigger_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        write_trigger_q <= 1'b0;
        read_trigger_q  <= 1'b0;
      end else begin
        write_trigger_q <= i_access.write && !i_hw_clear;
        read_trigger_q  <= i_access.read && !i_hw_clear;
      end
    end

    assign o_write_trigger = write_trigger_q;
    assign o_read_trigger  = read_trigger_q;
  end else begin : g_no_trigger
    assign o_write_trigger = 1'b0;
    assign o_read_trigger  = 1'b0;
  end

endmodule

// File: rtl/rggen_bit_field_event_counter.sv
// Multi-channel event-counter register field: slices the SW bus per channel,
// decodes per-channel accesses and instantiates one counter per channel.
module rggen_bit_field_event_counter
  import rggen_bit_field_event_counter_pkg::*;
#(
  parameter int unsigned                  WIDTH             = 8,
  parameter int unsigned                  CHANNELS          = 4,
  parameter logic [CHANNELS*WIDTH-1:0]    INITIAL_VALUE     = '0,
  parameter rggen_read_action_e           SW_READ_ACTION    = RggenReadDefault,
  parameter rggen_write_action_e          SW_WRITE_ACTION   = RggenWriteDefault,
  parameter rggen_precedence_e            PRECEDENCE_ACCESS = RggenHwAccess,
  parameter bit                           WRAP              = RggenCounterSaturate,
  parameter logic [WIDTH-1:0]             THRESHOLD         = '1,
  parameter bit                           TRIGGER           = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_sw_valid,
  input  logic [CHANNELS*WIDTH-1:0] i_sw_read_mask,
  input  logic                      i_sw_write_enable,
  input  logic [CHANNELS*WIDTH-1:0] i_sw_write_mask,
  input  logic [CHANNELS*WIDTH-1:0] i_sw_write_data,
  output logic [CHANNELS*WIDTH-1:0] o_sw_read_data,
  output logic [CHANNELS-1:0]       o_write_trigger,
  output logic [CHANNELS-1:0]       o_read_trigger,
  input  logic [CHANNELS-1:0]       i_hw_up,
  input  logic [CHANNELS-1:0]       i_hw_down,
  input  logic [CHANNELS-1:0]       i_hw_clear,
  output logic [CHANNELS*WIDTH-1:0] o_value,
  output logic [CHANNELS-1:0]       o_overflow,
  output logic [CHANNELS-1:0]       o_threshold
);

  logic [CHANNELS*WIDTH-1:0] value;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
    counter_access_t access;

    assign access = decode_access(i_sw_valid, i_sw_write_enable,
                                  |i_sw_read_mask[c*WIDTH+:WIDTH],
                                  |i_sw_write_mask[c*WIDTH+:WIDTH],
                                  SW_READ_ACTION, SW_WRITE_ACTION);

    rggen_event_counter_channel #(
      .WIDTH             (WIDTH),
      .INITIAL_VALUE     (INITIAL_VALUE[c*WIDTH+:WIDTH]),
      .SW_READ_ACTION    (SW_READ_ACTION),
      .SW_WRITE_ACTION   (SW_WRITE_ACTION),
      .PRECEDENCE_ACCESS (PRECEDENCE_ACCESS),
      .WRAP              (WRAP),
      .THRESHOLD         (THRESHOLD),
      .TRIGGER           (TRIGGER)
    ) u_channel (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_access        (access),
      .i_write_mask    (i_sw_write_mask[c*WIDTH+:WIDTH]),
      .i_write_data    (i_sw_write_data[c*WIDTH+:WIDTH]),
      .i_hw_up         (i_hw_up[c]),
      .i_hw_down       (i_hw_down[c]),
      .i_hw_clear      (i_hw_clear[c]),
      .o_value         (value[c*WIDTH+:WIDTH]),
      .o_overflow      (o_overflow[c]),
      .o_threshold     (o_threshold[c]),
      .o_write_trigger (o_write_trigger[c]),
      .o_read_trigger  (o_read_trigger[c])
    );
  end

  assign o_value        = value;
  assign o_sw_read_data = (SW_READ_ACTION == RggenReadNone) ? '0 : value;

endmodule

// File: tb/tb_rggen_bit_field_event_counter.sv
// Three differently configured counter fields share one random stimulus stream;
// a reference model queues expected outputs and a monitor compares each cycle.
module tb_rggen_bit_field_event_counter;
  import rggen_bit_field_event_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw_valid, sw_we;
  logic [7:0] rmask, wmask, wdata;
  logic [1:0] hw_up, hw_down, hw_clear;

  logic [7:0] rd_o    [3];
  logic [7:0] value_o [3];
  logic [1:0] wt_o    [3];
  logic [1:0] rt_o    [3];
  logic [1:0] ovf_o   [3];
  logic [1:0] thr_o   [3];

  // Model configuration: read 0=default 1=clear 2=none; write 0=default 1=w1c.
  int         cfg_read   [3] = '{0, 1, 2};
  int         cfg_write  [3] = '{0, 0, 1};
  bit         cfg_swprec [3] = '{0, 1, 0};
  bit         cfg_wrap   [3] = '{0, 1, 0};
  int         cfg_thr    [3] = '{15, 8, 4};
  bit         cfg_trig   [3] = '{0, 1, 1};
  logic [7:0] cfg_init   [3] = '{8'h00, 8'h3C, 8'hF1};

  int cnt_m [3][2];
  bit ovf_m [3][2];
  bit wt_m  [3][2];
  bit rt_m  [3][2];

  typedef struct packed {
    logic [2:0][7:0] value;
    logic [2:0][7:0] rd;
    logic [2:0][1:0] ovf;
    logic [2:0][1:0] thr;
    logic [2:0][1:0] wt;
    logic [2:0][1:0] rt;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  rggen_bit_field_event_counter #(
    .WIDTH(4), .CHANNELS(2), .INITIAL_VALUE(8'h00),
    .SW_READ_ACTION(RggenReadDefault), .SW_WRITE_ACTION(RggenWriteDefault),
    .PRECEDENCE_ACCESS(RggenHwAccess), .WRAP(1'b0), .THRESHOLD(4'hF), .TRIGGER(1'b0)
  ) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_valid(sw_valid), .i_sw_read_mask(rmask),
    .i_sw_write_enable(sw_we), .i_sw_write_mask(wmask), .i_sw_write_data(wdata),
    .o_sw_read_data(rd_o[0]), .o_write_trigger(wt_o[0]), .o_read_trigger(rt_o[0]),
    .i_hw_up(hw_up), .i_hw_down(hw_down), .i_hw_clear(hw_clear),
    .o_value(value_o[0]), .o_overflow(ovf_o[0]), .o_threshold(thr_o[0])
  );

  rggen_bit_field_event_counter #(
    .WIDTH(4), .CHANNELS(2), .INITIAL_VALUE(8'h3C),
    .SW_READ_ACTION(RggenReadClear), .SW_WRITE_ACTION(RggenWriteDefault),
    .PRECEDENCE_ACCESS(RggenSwAccess), .WRAP(1'b1), .THRESHOLD(4'h8), .TRIGGER(1'b1)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_valid(sw_valid), .i_sw_read_mask(rmask),
    .i_sw_write_enable(sw_we), .i_sw_write_mask(wmask), .i_sw_write_data(wdata),
    .o_sw_read_data(rd_o[1]), .o_write_trigger(wt_o[1]), .o_read_trigger(rt_o[1]),
    .i_hw_up(hw_up), .i_hw_down(hw_down), .i_hw_clear(hw_clear),
    .o_value(value_o[1]), .o_overflow(ovf_o[1]), .o_threshold(thr_o[1])
  );

  rggen_bit_field_event_counter #(
    .WIDTH(4), .CHANNELS(2), .INITIAL_VALUE(8'hF1),
    .SW_READ_ACTION(RggenReadNone), .SW_WRITE_ACTION(RggenWrite1Clear),
    .PRECEDENCE_ACCESS(RggenHwAccess), .WRAP(1'b0), .THRESHOLD(4'h4), .TRIGGER(1'b1)
  ) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_valid(sw_valid), .i_sw_read_mask(rmask),
    .i_sw_write_enable(sw_we), .i_sw_write_mask(wmask), .i_sw_write_data(wdata),
    .o_sw_read_data(rd_o[2]), .o_write_trigger(wt_o[2]), .o_read_trigger(rt_o[2]),
    .i_hw_up(hw_up), .i_hw_down(hw_down), .i_hw_clear(hw_clear),
    .o_value(value_o[2]), .o_overflow(ovf_o[2]), .o_threshold(thr_o[2])
  );

  function automatic exp_t snapshot();
    exp_t e;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 2; c++) begin
        e.value[d][c*4+:4] = 4'(cnt_m[d][c]);
        e.ovf[d][c]        = ovf_m[d][c];
        e.thr[d][c]        = (cnt_m[d][c] >= cfg_thr[d]);
        e.wt[d][c]         = wt_m[d][c];
        e.rt[d][c]         = rt_m[d][c];
      end
      e.rd[d] = (cfg_read[d] == 2) ? 8'h00 : e.value[d];
    end
    return e;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 2; c++) begin
        cnt_m[d][c] = int'(cfg_init[d][c*4+:4]);
        ovf_m[d][c] = 1'b0;
        wt_m[d][c]  = 1'b0;
        rt_m[d][c]  = 1'b0;
      end
    end
  endfunction

  task automatic drive_idle();
    sw_valid = 1'b0; sw_we = 1'b0;
    rmask = '0; wmask = '0; wdata = '0;
    hw_up = '0; hw_down = '0; hw_clear = '0;
  endtask

  task automatic cycle(input logic v, input logic w, input logic [7:0] rm,
                       input logic [7:0] wm, input logic [7:0] wd,
                       input logic [1:0] up, input logic [1:0] dn, input logic [1:0] clr);
    @(negedge clk);
    sw_valid = v; sw_we = w; rmask = rm; wmask = wm; wdata = wd;
    hw_up = up; hw_down = dn; hw_clear = clr;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 2; c++) begin
        logic [3:0] old4, m4, d4, wr4;
        int         nv, delta;
        bit         rd_hit, wr_hit, keep, ev;
        old4   = 4'(cnt_m[d][c]);
        m4     = wm[c*4+:4];
        d4     = wd[c*4+:4];
        delta  = int'(up[c]) - int'(dn[c]);
        rd_hit = v && (rm[c*4+:4] != 4'h0) && (cfg_read[d] != 2);
        wr_hit = v && w && (m4 != 4'h0) && (cfg_write[d] != 2);
        keep   = 1'b1;
        if (clr[c]) begin
          cnt_m[d][c] = 0;
          ovf_m[d][c] = 1'b0;
          wt_m[d][c]  = 1'b0;
          rt_m[d][c]  = 1'b0;
        end else begin
          if (wr_hit) begin
            wr4  = (cfg_write[d] == 0) ? ((old4 & ~m4) | (d4 & m4)) : (old4 & ~(d4 & m4));
            nv   = int'(wr4);
            keep = 1'b0;
            if (cfg_swprec[d]) delta = 0;
          end else if (rd_hit && (cfg_read[d] == 1)) begin
            nv   = 0;
            keep = 1'b0;
          end else begin
            nv = cnt_m[d][c];
          end
          nv = nv + delta;
          ev = (nv > 15) || (nv < 0);
          if (ev) nv = cfg_wrap[d] ? (nv & 15) : ((nv > 15) ? 15 : 0);
          cnt_m[d][c] = nv;
          ovf_m[d][c] = (keep && ovf_m[d][c]) || ev;
          wt_m[d][c]  = cfg_trig[d] && wr_hit;
          rt_m[d][c]  = cfg_trig[d] && rd_hit;
        end
      end
    end
    exp_q.push_back(snapshot());
  endtask

  task automatic chk(input string name, input int d, input logic [7:0] act,
                     input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d at %0t: got %h, expected %h", name, d, $time, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int d = 0; d < 3; d++) begin
          chk("value", d, value_o[d], e.value[d]);
          chk("read_data", d, rd_o[d], e.rd[d]);
          chk("overflow", d, {6'd0, ovf_o[d]}, {6'd0, e.ovf[d]});
          chk("threshold", d, {6'd0, thr_o[d]}, {6'd0, e.thr[d]});
          chk("write_trigger", d, {6'd0, wt_o[d]}, {6'd0, e.wt[d]});
          chk("read_trigger", d, {6'd0, rt_o[d]}, {6'd0, e.rt[d]});
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    @(negedge clk);
    exp_q.push_back(snapshot());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    repeat (3) cycle(0, 0, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00);
    repeat (16) cycle(0, 0, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00);
    cycle(0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10);
    repeat (5) cycle(0, 0, 8'h00, 8'h00, 8'h00, 2'b10, 2'b00, 2'b00);
    cycle(1, 0, 8'hF0, 8'h00, 8'h00, 2'b10, 2'b00, 2'b00);
    cycle(1, 1, 8'h00, 8'h0F, 8'h0A, 2'b01, 2'b00, 2'b00);
    cycle(0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01);
    repeat (9) cycle(0, 0, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00);
    cycle(0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01);
    cycle(1, 1, 8'h00, 8'hF0, 8'h50, 2'b00, 2'b00, 2'b00);
    cycle(0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    cycle(1, 1, 8'hFF, 8'h0F, 8'h0F, 2'b11, 2'b10, 2'b00);
    repeat (4) cycle(0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] rm, wm;
      rm = 8'($urandom);
      wm = 8'($urandom);
      if ($urandom_range(0, 2) == 0) rm[3:0] = 4'h0;
      if ($urandom_range(0, 2) == 0) wm[7:4] = 4'h0;
      cycle(($urandom_range(0, 3) == 0), 1'($urandom), rm, wm, 8'($urandom),
            2'($urandom), 2'($urandom & $urandom),
            {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)});
    end

    repeat (6) cycle(0, 0, 8'h00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00);
    cycle(1, 1, 8'h00, 8'h33, 8'h33, 2'b11, 2'b00, 2'b00);
    // Reset pulse entirely between clock edges: only an asynchronous reset sees it.
    @(negedge clk);
    drive_idle();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    exp_q.push_back(snapshot());

    for (int i = 0; i < 60; i++) begin
      cycle(($urandom_range(0, 2) == 0), 1'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 2'($urandom), 2'($urandom), 2'b00);
    end

    @(negedge clk);
    drive_idle();
    repeat (3) @(posedge clk);
    #2;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected records left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
